// File: rtl/aes_job_sequencer.sv
// aes_job_sequencer: host-side sequencer for the masked AES core.
// It owns the key-load and data-load handshakes and runs each job as N back-to-back
// encryptions. Each encryption either reuses the job plaintext or chains the previous
// ciphertext. Every ciphertext (or a timeout abort) is returned through a valid/ready port.
// A watchdog bounds each wait on the core. A registered round-9 trigger supports capture.
module aes_job_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [127:0]     key_in,
    input  logic             key_wr,
    output logic             key_err,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [127:0]     job_pt,
    input  logic [CNT_W-1:0] job_rep,
    input  logic             job_chain,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [127:0]     res_ct,
    output logic [CNT_W-1:0] res_idx,
    output logic             res_err,
    output logic [127:0]     core_Din0,
    output logic [127:0]     core_Kin,
    output logic             core_Drdy,
    output logic             core_Krdy,
    output logic             core_EN,
    input  logic [127:0]     core_Dout0,
    input  logic             core_Dvld,
    input  logic             core_Kvld,
    input  logic             core_BSY,
    input  logic             core_round9,
    output logic             trig
);
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_KWAIT, S_LOAD, S_RUN, S_OUT
    } state_t;

    state_t state_reg, state_next;

    logic [127:0]     shadow_reg, kin_reg, pt_reg, din_reg, res_ct_reg;
    logic [CNT_W-1:0] rep_reg, cnt_reg, res_idx_reg;
    logic             chain_reg, key_pend_reg, key_loaded_reg, key_err_reg;
    logic             res_valid_reg, res_err_reg;
    logic             drdy_reg, krdy_reg, en_reg, trig_reg;
    logic [WD_W-1:0]  wd_reg;
    logic [CNT_W:0]   cnt_inc;

    logic timeout, key_req, last_iter;
    logic job_fire, key_ok, key_fail, res_ok, res_abort, res_take, next_iter;

    // The sequencing relies only on Kvld/Dvld, so the busy flag is informational.
    logic unused_bsy;
    assign unused_bsy = core_BSY;

    assign timeout   = (wd_reg == WD_W'(TIMEOUT));
    // A write arriving this cycle counts as pending, so a key load starts without an extra idle cycle.
    assign key_req   = key_pend_reg | key_wr;
    assign cnt_inc   = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
    assign last_iter = (cnt_inc == {1'b0, rep_reg});
    // A pending or simultaneous key write wins over a job offer.
    assign job_ready = (state_reg == S_IDLE) & key_loaded_reg & ~key_pend_reg & ~key_wr;

    assign key_err   = key_err_reg;
    assign res_valid = res_valid_reg;
    assign res_ct    = res_ct_reg;
    assign res_idx   = res_idx_reg;
    assign res_err   = res_err_reg;
    assign core_Din0 = din_reg;
    assign core_Kin  = kin_reg;
    assign core_Drdy = drdy_reg;
    assign core_Krdy = krdy_reg;
    assign core_EN   = en_reg;
    assign trig      = trig_reg;

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        state_next = state_reg;
        job_fire   = 1'b0;
        key_ok     = 1'b0;
        key_fail   = 1'b0;
        res_ok     = 1'b0;
        res_abort  = 1'b0;
        res_take   = 1'b0;
        next_iter  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (key_req) begin
                    state_next = S_KEY;
                end else if (job_valid && job_ready) begin
                    job_fire   = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_KEY: begin
                if (core_Kvld) begin
                    key_ok     = 1'b1;
                    state_next = key_wr ? S_KEY : S_IDLE;
                end else begin
                    state_next = S_KWAIT;
                end
            end
            S_KWAIT: begin
                if (core_Kvld) begin
                    key_ok     = 1'b1;
                    state_next = key_req ? S_KEY : S_IDLE;
                end else if (timeout) begin
                    key_fail   = 1'b1;
                    state_next = key_req ? S_KEY : S_IDLE;
                end
            end
            S_LOAD: begin
                if (core_Dvld) begin
                    res_ok     = 1'b1;
                    state_next = S_OUT;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (core_Dvld) begin
                    res_ok     = 1'b1;
                    state_next = S_OUT;
                end else if (timeout) begin
                    res_abort  = 1'b1;
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    res_take = 1'b1;
                    // When the job ends, a pending key goes straight to loading.
                    if (res_err_reg || last_iter) begin
                        state_next = key_req ? S_KEY : S_IDLE;
                    end else begin
                        next_iter  = 1'b1;
                        state_next = S_LOAD;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Key shadow, pending flag, loaded/error status and the key presented to the core.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            shadow_reg     <= '0;
            kin_reg        <= '0;
            key_pend_reg   <= 1'b0;
            key_loaded_reg <= 1'b0;
            key_err_reg    <= 1'b0;
        end else begin
            if (key_wr) begin
                shadow_reg <= key_in;
            end
            if (state_next == S_KEY) begin
                kin_reg      <= key_wr ? key_in : shadow_reg;
                key_pend_reg <= 1'b0;
            end else if (key_wr) begin
                key_pend_reg <= 1'b1;
            end
            if (key_ok) begin
                key_loaded_reg <= 1'b1;
            end else if (key_fail) begin
                key_loaded_reg <= 1'b0;
            end
            if (key_wr) begin
                key_err_reg <= 1'b0;
            end else if (key_fail) begin
                key_err_reg <= 1'b1;
            end
        end
    end

    // Job context, iteration counter, next core input and the result holding register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pt_reg        <= '0;
            rep_reg       <= '0;
            chain_reg     <= 1'b0;
            cnt_reg       <= '0;
            din_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_ct_reg    <= '0;
            res_idx_reg   <= '0;
            res_err_reg   <= 1'b0;
        end else begin
            if (job_fire) begin
                pt_reg    <= job_pt;
                rep_reg   <= (job_rep == '0) ? CNT_W'(1) : job_rep;
                chain_reg <= job_chain;
                cnt_reg   <= '0;
                din_reg   <= job_pt;
            end else if (next_iter) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
                din_reg <= chain_reg ? res_ct_reg : pt_reg;
            end
            if (res_ok) begin
                res_valid_reg <= 1'b1;
                res_ct_reg    <= core_Dout0;
                res_idx_reg   <= cnt_reg;
                res_err_reg   <= 1'b0;
            end else if (res_abort) begin
                res_valid_reg <= 1'b1;
                res_ct_reg    <= '0;
                res_idx_reg   <= cnt_reg;
                res_err_reg   <= 1'b1;
            end else if (res_take) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    // Core strobes, enable, capture trigger and the watchdog counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            en_reg   <= 1'b0;
            krdy_reg <= 1'b0;
            drdy_reg <= 1'b0;
            trig_reg <= 1'b0;
            wd_reg   <= '0;
        end else begin
            en_reg   <= 1'b1;
            krdy_reg <= (state_next == S_KEY);
            drdy_reg <= (state_next == S_LOAD);
            trig_reg <= core_round9 & (state_reg == S_RUN);
            if (state_next == S_KEY || state_next == S_LOAD) begin
                wd_reg <= '0;
            end else if ((state_reg == S_KEY || state_reg == S_KWAIT ||
                          state_reg == S_LOAD || state_reg == S_RUN) && !timeout) begin
                wd_reg <= wd_reg + WD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes_job_sequencer.sv
// tb_aes_job_sequencer: directed bench with a stub AES core and a result scoreboard.
module tb_aes_job_sequencer;
    localparam int CNT_W = 16;
    localparam int TMO   = 15;
    localparam int KLAT  = 3;
    localparam int DLAT  = 6;

    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             CLK, RSTn;
    logic [127:0]     key_in;
    logic             key_wr, key_err;
    logic             job_valid, job_ready;
    logic [127:0]     job_pt;
    logic [CNT_W-1:0] job_rep;
    logic             job_chain;
    logic             res_valid, res_ready;
    logic [127:0]     res_ct;
    logic [CNT_W-1:0] res_idx;
    logic             res_err;
    logic [127:0]     core_Din0, core_Kin;
    logic             core_Drdy, core_Krdy, core_EN;
    logic [127:0]     core_Dout0 = '0;
    logic             core_Dvld = 1'b0, core_Kvld = 1'b0, core_BSY = 1'b0, core_round9 = 1'b0;
    logic             trig;

    aes_job_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .key_in(key_in), .key_wr(key_wr), .key_err(key_err),
        .job_valid(job_valid), .job_ready(job_ready), .job_pt(job_pt),
        .job_rep(job_rep), .job_chain(job_chain),
        .res_valid(res_valid), .res_ready(res_ready), .res_ct(res_ct),
        .res_idx(res_idx), .res_err(res_err),
        .core_Din0(core_Din0), .core_Kin(core_Kin),
        .core_Drdy(core_Drdy), .core_Krdy(core_Krdy), .core_EN(core_EN),
        .core_Dout0(core_Dout0), .core_Dvld(core_Dvld), .core_Kvld(core_Kvld),
        .core_BSY(core_BSY), .core_round9(core_round9),
        .trig(trig)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Stub cipher: the FIPS-197 vector for (K0, PT0), otherwise rotate-left-8 xor key.
    function automatic logic [127:0] ref_core(input logic [127:0] k, input logic [127:0] d);
        if (k == K0 && d == PT0) return CT0;
        return {d[119:0], d[127:120]} ^ k;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stub core: Kvld KLAT cycles after Krdy, round9 then Dvld DLAT cycles after Drdy.
    bit           core_dead = 1'b0;
    logic [127:0] stub_key = '0, stub_din = '0;
    int           kcnt = 0, dcnt = 0;
    always @(posedge CLK) begin
        core_Kvld   <= 1'b0;
        core_Dvld   <= 1'b0;
        core_round9 <= 1'b0;
        if (core_Krdy) begin
            stub_key <= core_Kin;
            kcnt     <= KLAT;
        end else if (kcnt > 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) core_Kvld <= 1'b1;
        end
        if (core_Drdy) begin
            stub_din <= core_Din0;
            dcnt     <= DLAT;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 2 && !core_dead) core_round9 <= 1'b1;
            if (dcnt == 1 && !core_dead) begin
                core_Dvld  <= 1'b1;
                core_Dout0 <= ref_core(stub_key, stub_din);
            end
        end
        core_BSY <= (dcnt > 1);
    end

    // Scoreboard entries: {ct[127:0], idx[15:0], err}.
    logic [144:0] sb[$];
    logic [127:0] din_log[$];
    int krdy_cnt = 0, krdy_cyc = -100, drdy_cnt = 0, drdy_cyc = -100, drdy_stall = 0;
    int hs_cyc = -100, vrise_cyc = -100, r9_cyc = -100, trig_cnt = 0;
    int stall_idx = -1, stall_left = 0, stalled = 0;

    // Result driver: ready high except while stalling the chosen index.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (res_valid && res_idx == stall_idx[15:0] && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
                stalled++;
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each result handshake, tracks strobes and trig.
    initial begin
        logic [144:0] e;
        logic [144:0] hold;
        bit holding;
        bit prev_valid;
        holding = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge CLK);
            if (RSTn) begin
                if (core_Krdy) begin krdy_cnt++; krdy_cyc = cyc; end
                if (core_Drdy) begin
                    drdy_cnt++;
                    drdy_cyc = cyc;
                    din_log.push_back(core_Din0);
                    if (res_valid) drdy_stall++;
                end
                if (trig) begin
                    trig_cnt++;
                    chk("trig_lag", 160'(r9_cyc), 160'(cyc - 1));
                end
                if (core_round9) r9_cyc = cyc;
                if (res_valid && !prev_valid) vrise_cyc = cyc;
                prev_valid = res_valid;
                if (res_valid && !res_ready) begin
                    if (holding) chk("stall_stable", {res_ct, res_idx, res_err}, hold);
                    hold = {res_ct, res_idx, res_err};
                    holding = 1'b1;
                end else begin
                    holding = 1'b0;
                end
                if (res_valid && res_ready) begin
                    hs_cyc = cyc;
                    if (sb.size() == 0) begin
                        chk("unexpected_result", {res_ct, res_idx, res_err}, 160'h0);
                    end else begin
                        e = sb.pop_front();
                        $display("result idx=%0d err=%0b ct=%h", res_idx, res_err, res_ct);
                        chk("res_ct", res_ct, e[144:17]);
                        chk("res_idx", res_idx, e[16:1]);
                        chk("res_err", res_err, e[0]);
                    end
                end
            end else begin
                prev_valid = 1'b0;
                holding = 1'b0;
            end
        end
    end

    task automatic send_job(input logic [127:0] pt, input int rep, input bit chain,
                            input logic [127:0] k, input bit push);
        logic [127:0] x, ct;
        int r, n;
        if (push) begin
            r = (rep == 0) ? 1 : rep;
            x = pt;
            for (int i = 0; i < r; i++) begin
                ct = ref_core(k, x);
                sb.push_back({ct, 16'(i), 1'b0});
                x = chain ? ct : pt;
            end
        end
        @(posedge CLK);
        #1;
        job_pt = pt; job_rep = 16'(rep); job_chain = chain; job_valid = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!job_ready && n < 60);
        chk("job_accept", job_ready, 1);
        @(posedge CLK);
        #1;
        job_valid = 1'b0;
        chk("drdy_after_handshake", core_Drdy, 1);
        $display("job pt=%h rep=%0d chain=%0b", pt, rep, chain);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin @(negedge CLK); n++; end while (!(sb.size() == 0 && job_ready) && n < 400);
        chk(name, {sb.size() == 0, job_ready}, 2'b11);
    endtask

    function automatic logic any_out();
        return |{key_err, job_ready, res_valid, res_ct, res_idx, res_err,
                 core_Din0, core_Kin, core_Drdy, core_Krdy, core_EN, trig};
    endfunction

    initial begin
        #100000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int n, k0, d0;
        RSTn = 1'b1; key_in = '0; key_wr = 1'b0;
        job_valid = 1'b0; job_pt = '0; job_rep = '0; job_chain = 1'b0;
        #1 RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_outputs_zero", any_out(), 0);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        chk("core_en_after_reset", core_EN, 1);

        // Key load.
        @(posedge CLK);
        #1;
        key_in = K0; key_wr = 1'b1;
        @(posedge CLK);
        #1;
        key_wr = 1'b0;
        chk("krdy_next_cycle", core_Krdy, 1);
        chk("kin_value", core_Kin, K0);
        n = 0;
        do begin @(negedge CLK); n++; end while (!core_Kvld && n < 40);
        chk("kvld_seen", core_Kvld, 1);
        chk("job_ready_during_kvld", job_ready, 0);
        @(posedge CLK);
        #1;
        chk("job_ready_after_kvld", job_ready, 1);
        chk("krdy_single_cycle", krdy_cnt, 1);
        chk("key_err_clear", key_err, 0);
        $display("key loaded %h", K0);

        // Single encryption with trig.
        trig_cnt = 0;
        send_job(PT0, 1, 1'b0, K0, 1'b1);
        wait_done("job1_done");
        chk("trig_once", trig_cnt, 1);

        // rep=3 re-encrypt with a 10-cycle stall on idx 1.
        stall_idx = 1; stall_left = 10; stalled = 0; drdy_stall = 0;
        send_job(PT0, 3, 1'b0, K0, 1'b1);
        wait_done("rep3_done");
        chk("stall_cycles", stalled, 10);
        chk("no_drdy_while_result_pending", drdy_stall, 0);
        stall_idx = -1;

        // rep=2 chained.
        din_log.delete();
        send_job(PT0, 2, 1'b1, K0, 1'b1);
        wait_done("chain_done");
        chk("chain_drdy_count", din_log.size(), 2);
        if (din_log.size() >= 2) chk("chain_din1", din_log[1], CT0);

        // rep=0 behaves as one encryption.
        d0 = drdy_cnt;
        send_job(PT0, 0, 1'b0, K0, 1'b1);
        wait_done("rep0_done");
        chk("rep0_single_drdy", drdy_cnt - d0, 1);

        // Key write during RUN: job finishes with the old key, then the new one loads.
        k0 = krdy_cnt;
        send_job(PT0, 2, 1'b0, K0, 1'b1);
        @(posedge CLK);
        #1;
        key_in = K1; key_wr = 1'b1;
        @(posedge CLK);
        #1;
        key_wr = 1'b0;
        wait_done("keyswap_done");
        chk("krdy_after_final_handshake", 160'(krdy_cyc), 160'(hs_cyc + 1));
        chk("keyswap_krdy_count", krdy_cnt - k0, 1);
        send_job(PT0, 1, 1'b0, K1, 1'b1);
        wait_done("newkey_done");

        // Dead core: a single abort result, remaining reps dropped.
        core_dead = 1'b1;
        d0 = drdy_cnt;
        sb.push_back({128'h0, 16'h0, 1'b1});
        send_job(PT0, 4, 1'b0, K1, 1'b0);
        wait_done("abort_done");
        chk("abort_latency", 160'(vrise_cyc - drdy_cyc), 160'(TMO + 1));
        chk("abort_drops_reps", drdy_cnt - d0, 1);

        // Reset mid-RUN drops the job and the key.
        send_job(PT0, 1, 1'b0, K1, 1'b0);
        repeat (3) @(posedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        chk("midrun_reset_outputs_zero", any_out(), 0);
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("key_loaded_cleared", job_ready, 0);
        chk("no_result_after_reset", res_valid, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
